instr_queue: RTL and testbench

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue.sv | 175 +++++++++++++++++
 tb/tb_instr_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_queue
//  Purpose  : Fetch-to-decode instruction FIFO with head predecode
//             (register-use flags and illegal-opcode detection).
//             Optional macro INSTR_QUEUE_BYPASS_EN lets an empty queue present
//             the fetch input on the head outputs in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module instr_queue #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic [ADDR_WIDTH-1:0]     pc_in,
   input  logic [ADDR_WIDTH-1:0]     next_pc_in,
   input  logic [31:0]               instruction_in,
   input  logic                      valid_in,
   output logic                      ready_out,

   input  logic                      stall,
   input  logic                      invalidate,

   output logic [ADDR_WIDTH-1:0]     pc_out,
   output logic [ADDR_WIDTH-1:0]     next_pc_out,
   output logic [31:0]               instruction_out,
   output logic                      valid_out,
   output logic                      uses_rs1_out,
   output logic                      uses_rs2_out,
   output logic                      illegal_out,
   output logic [$clog2(DEPTH):0]    count_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // Entry storage: written on push only, never reset
   logic [ADDR_WIDTH-1:0] pc_mem      [DEPTH];
   logic [ADDR_WIDTH-1:0] next_pc_mem [DEPTH];
   logic [31:0]           instr_mem   [DEPTH];

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;

   logic                  queue_empty;
   logic                  bypass_pop;
   logic                  push;
   logic                  pop;

   logic [ADDR_WIDTH-1:0] head_pc;
   logic [ADDR_WIDTH-1:0] head_next_pc;
   logic [31:0]           head_instr;
   logic                  head_valid;

   logic [6:0]            head_opcode;
   logic [2:0]            head_funct3;
   logic                  dec_rs1;
   logic                  dec_rs2;
   logic                  dec_legal;

   assign queue_empty = (count == '0);
   assign ready_out   = (count != FULL_COUNT);
   assign count_out   = count;

`ifdef INSTR_QUEUE_BYPASS_EN
   // Empty queue forwards the fetch entry; consumed in flight, it is never stored
   logic bypass_active;
   assign bypass_active = queue_empty && valid_in;
   assign head_valid    = !queue_empty || valid_in;
   assign head_pc       = bypass_active ? pc_in          : pc_mem[rd_ptr];
   assign head_next_pc  = bypass_active ? next_pc_in     : next_pc_mem[rd_ptr];
   assign head_instr    = bypass_active ? instruction_in : instr_mem[rd_ptr];
   assign bypass_pop    = bypass_active && !stall && !invalidate;
`else
   assign head_valid    = !queue_empty;
   assign head_pc       = pc_mem[rd_ptr];
   assign head_next_pc  = next_pc_mem[rd_ptr];
   assign head_instr    = instr_mem[rd_ptr];
   assign bypass_pop    = 1'b0;
`endif

   // Ready comes from the registered count, so a full queue refuses even when popping
   assign push = valid_in && ready_out && !invalidate && !bypass_pop;
   assign pop  = head_valid && !stall && !invalidate && !bypass_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (invalidate) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]      <= pc_in;
         next_pc_mem[wr_ptr] <= next_pc_in;
         instr_mem[wr_ptr]   <= instruction_in;
      end
   end

   assign head_opcode = head_instr[6:0];
   assign head_funct3 = head_instr[14:12];

   always_comb begin
      dec_rs1   = 1'b0;
      dec_rs2   = 1'b0;
      dec_legal = 1'b0;
      case (head_opcode)
         OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE: begin
            dec_legal = 1'b1;
         end
         OP_JALR, OP_LOAD, OP_IMM: begin
            dec_legal = 1'b1;
            dec_rs1   = 1'b1;
         end
         OP_BRANCH, OP_STORE, OP_REG: begin
            dec_legal = 1'b1;
            dec_rs1   = 1'b1;
            dec_rs2   = 1'b1;
         end
         OP_SYSTEM: begin
            // CSRRW/CSRRS/CSRRC read rs1; immediate CSR forms and ECALL/EBREAK do not
            dec_legal = 1'b1;
            dec_rs1   = (head_funct3 == 3'b001) || (head_funct3 == 3'b010) ||
                        (head_funct3 == 3'b011);
         end
         default: begin
            dec_legal = 1'b0;
         end
      endcase
   end

   assign valid_out       = head_valid;
   assign pc_out          = head_pc;
   assign next_pc_out     = head_next_pc;
   assign instruction_out = head_instr;
   assign uses_rs1_out    = head_valid && dec_rs1;
   assign uses_rs2_out    = head_valid && dec_rs2;
   assign illegal_out     = head_valid && !dec_legal;

endmodule
`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_queue
//  Purpose  : Directed and randomized checking of instr_queue against a
//             queue-based reference model with a table-driven predecoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_queue;

   localparam int DEPTH      = 4;
   localparam int ADDR_WIDTH = 32;

   localparam logic [6:0] LEGAL_OPS [11] = '{7'b0110111, 7'b0010111, 7'b1101111,
      7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
      7'b0001111, 7'b1110011};
   localparam logic [6:0] RS1_OPS [6] = '{7'b1100111, 7'b0000011, 7'b0010011,
      7'b1100011, 7'b0100011, 7'b0110011};
   localparam logic [6:0] RS2_OPS [3] = '{7'b1100011, 7'b0100011, 7'b0110011};

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] npc;
      logic [31:0] ins;
   } ent_t;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [ADDR_WIDTH-1:0]  pc_in;
   logic [ADDR_WIDTH-1:0]  next_pc_in;
   logic [31:0]            instruction_in;
   logic                   valid_in;
   logic                   ready_out;
   logic                   stall;
   logic                   invalidate;
   logic [ADDR_WIDTH-1:0]  pc_out;
   logic [ADDR_WIDTH-1:0]  next_pc_out;
   logic [31:0]            instruction_out;
   logic                   valid_out;
   logic                   uses_rs1_out;
   logic                   uses_rs2_out;
   logic                   illegal_out;
   logic [$clog2(DEPTH):0] count_out;

   int   n_vec  = 0;
   int   n_miss = 0;
   ent_t model_q[$];

   instr_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .pc_in           (pc_in),
      .next_pc_in      (next_pc_in),
      .instruction_in  (instruction_in),
      .valid_in        (valid_in),
      .ready_out       (ready_out),
      .stall           (stall),
      .invalidate      (invalidate),
      .pc_out          (pc_out),
      .next_pc_out     (next_pc_out),
      .instruction_out (instruction_out),
      .valid_out       (valid_out),
      .uses_rs1_out    (uses_rs1_out),
      .uses_rs2_out    (uses_rs2_out),
      .illegal_out     (illegal_out),
      .count_out       (count_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_rs1(input logic [31:0] ins);
      for (int i = 0; i < 6; i++) if (ins[6:0] == RS1_OPS[i]) return 1'b1;
      return (ins[6:0] == 7'b1110011) && (ins[14:12] >= 3'd1) && (ins[14:12] <= 3'd3);
   endfunction

   function automatic bit ref_rs2(input logic [31:0] ins);
      for (int i = 0; i < 3; i++) if (ins[6:0] == RS2_OPS[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit ref_illegal(input logic [31:0] ins);
      for (int i = 0; i < 11; i++) if (ins[6:0] == LEGAL_OPS[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = LEGAL_OPS[$urandom_range(0, 10)];
      return w;
   endfunction

   task automatic check_model();
      ent_t h;
      bit   hv;
      hv = (model_q.size() != 0);
      h  = hv ? model_q[0] : '0;
`ifdef INSTR_QUEUE_BYPASS_EN
      if (!hv && valid_in) begin
         hv = 1'b1;
         h  = '{pc: pc_in, npc: next_pc_in, ins: instruction_in};
      end
`endif
      chk("count", 64'(count_out), 64'(model_q.size()));
      chk("count_bound", 64'(count_out <= DEPTH), 64'd1);
      chk("valid", 64'(valid_out), 64'(hv));
      chk("ready", 64'(ready_out), 64'(model_q.size() < DEPTH));
      if (hv) begin
         chk("pc", 64'(pc_out), 64'(h.pc));
         chk("next_pc", 64'(next_pc_out), 64'(h.npc));
         chk("instr", 64'(instruction_out), 64'(h.ins));
      end
      chk("rs1", 64'(uses_rs1_out), 64'(hv && ref_rs1(h.ins)));
      chk("rs2", 64'(uses_rs2_out), 64'(hv && ref_rs2(h.ins)));
      chk("illegal", 64'(illegal_out), 64'(hv && ref_illegal(h.ins)));
   endtask

   // Called just after a rising edge; applies inputs, checks, advances one cycle
   task automatic step(input logic r, input logic v, input logic st, input logic inv,
                       input logic [31:0] p, input logic [31:0] np, input logic [31:0] ins);
      int  sz;
      bit  do_push;
      bit  do_pop;
      reset = r; valid_in = v; stall = st; invalidate = inv;
      pc_in = p; next_pc_in = np; instruction_in = ins;
      #1;
      check_model();
      sz      = model_q.size();
      do_push = v && (sz < DEPTH);
      do_pop  = (sz > 0) && !st;
`ifdef INSTR_QUEUE_BYPASS_EN
      if (sz == 0 && v && !st) do_push = 1'b0;
`endif
      if (r || inv) begin
         model_q.delete();
      end else begin
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back('{pc: p, npc: np, ins: ins});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; valid_in = 1'b0; stall = 1'b0; invalidate = 1'b0;
      pc_in = '0; next_pc_in = '0; instruction_in = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_count", 64'(count_out), 64'd0);
      chk("rst_valid", 64'(valid_out), 64'd0);
      chk("rst_ready", 64'(ready_out), 64'd1);
      chk("rst_rs1", 64'(uses_rs1_out), 64'd0);
      chk("rst_rs2", 64'(uses_rs2_out), 64'd0);
      chk("rst_illegal", 64'(illegal_out), 64'd0);

      // First push under stall: one-cycle latency, addi predecode
      step(0, 1, 1, 0, 32'h100, 32'h104, 32'h0000_0013);
      valid_in = 1'b0;
      #1;
      chk("first_valid", 64'(valid_out), 64'd1);
      chk("first_pc", 64'(pc_out), 64'h100);
      chk("first_rs1", 64'(uses_rs1_out), 64'd1);
      chk("first_rs2", 64'(uses_rs2_out), 64'd0);
      chk("first_count", 64'(count_out), 64'd1);

      // Fill under stall, then offer one more that must be ignored
      for (int k = 1; k < DEPTH; k++)
         step(0, 1, 1, 0, 32'h100 + 32'(4 * k), 32'h104 + 32'(4 * k), rand_instr());
      chk("full_count", 64'(count_out), 64'(DEPTH));
      chk("full_ready", 64'(ready_out), 64'd0);
      step(0, 1, 1, 0, 32'hBAD0, 32'hBAD4, rand_instr());
      chk("full_hold", 64'(count_out), 64'(DEPTH));

      // Drain in order
      for (int k = 0; k < DEPTH; k++) begin
         chk("order_pc", 64'(pc_out), 64'(32'h100 + 32'(4 * k)));
         step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      end

      // Full queue with pop and offered input: input refused
      for (int k = 0; k < DEPTH; k++)
         step(0, 1, 1, 0, 32'h200 + 32'(4 * k), 32'h204 + 32'(4 * k), rand_instr());
      step(0, 1, 0, 0, 32'hDEAD_0000, 32'hDEAD_0004, 32'h0000_0013);
      chk("fullpop_count", 64'(count_out), 64'(DEPTH - 1));
      chk("fullpop_ready", 64'(ready_out), 64'd1);
      for (int k = 0; k < DEPTH - 1; k++) step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);

      // Invalidate with three entries and a same-cycle offer
      for (int k = 0; k < 3; k++)
         step(0, 1, 1, 0, 32'h300 + 32'(4 * k), 32'h304 + 32'(4 * k), rand_instr());
      step(0, 1, 0, 1, 32'h3F0, 32'h3F4, rand_instr());
      chk("inv_count", 64'(count_out), 64'd0);
      chk("inv_valid", 64'(valid_out), 64'd0);
      step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);

      // Predecode boundaries: all-zero word and add
      step(0, 1, 1, 0, 32'h400, 32'h404, 32'h0000_0000);
      valid_in = 1'b0;
      #1;
      chk("zero_illegal", 64'(illegal_out), 64'd1);
      step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      step(0, 1, 1, 0, 32'h408, 32'h40C, 32'h00B5_0533);
      valid_in = 1'b0;
      #1;
      chk("add_rs2", 64'(uses_rs2_out), 64'd1);
      chk("add_illegal", 64'(illegal_out), 64'd0);

      // Mid-operation reset beats an offered push
      step(0, 1, 1, 0, 32'h500, 32'h504, rand_instr());
      step(1, 1, 0, 1, 32'h508, 32'h50C, rand_instr());
      chk("midrst_count", 64'(count_out), 64'd0);
      chk("midrst_ready", 64'(ready_out), 64'd1);

      // Random traffic with stalls across many pointer wraps
      for (int i = 0; i < 50 * DEPTH; i++)
         step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
              $urandom_range(0, 31) == 0, $urandom, $urandom, rand_instr());
      for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      chk("end_empty", 64'(count_out), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
